// File: rtl/thread_lsu.sv
// Per-thread load/store unit: issues one valid/ready memory transaction per LDR/STR
// and reports completion to the scheduler through lsu_state.
//   state      | meaning
//   S_IDLE     | waiting for a REQUEST with LDR or STR decoded
//   S_REQ      | valid held on one channel until ready or timeout
//   S_DONE     | result/error held until the scheduler's UPDATE
module thread_lsu #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [3:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [7:0]           rs,
  input  logic [7:0]           rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  localparam logic [3:0] CS_REQUEST = 4'b0100;
  localparam logic [3:0] CS_UPDATE  = 4'b0111;
  localparam int         CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b11
  } state_t;

  state_t               r_state,    w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,      w_cnt_nxt;
  logic                 r_rd_valid, w_rd_valid_nxt;
  logic                 r_wr_valid, w_wr_valid_nxt;
  logic [ADDR_BITS-1:0] r_rd_addr,  w_rd_addr_nxt;
  logic [ADDR_BITS-1:0] r_wr_addr,  w_wr_addr_nxt;
  logic [DATA_BITS-1:0] r_wr_data,  w_wr_data_nxt;
  logic [DATA_BITS-1:0] r_out,      w_out_nxt;
  logic                 r_err,      w_err_nxt;

  logic w_ready;
  logic w_timeout;

  // Only the channel that was issued is listened to.
  assign w_ready   = r_rd_valid ? mem_read_ready : mem_write_ready;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rd_valid_nxt = r_rd_valid;
    w_wr_valid_nxt = r_wr_valid;
    w_rd_addr_nxt  = r_rd_addr;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_out_nxt      = r_out;
    w_err_nxt      = r_err;
    if (enable) begin
      case (r_state)
        S_IDLE: begin
          if (core_state == CS_REQUEST && decoded_mem_read_enable) begin
            w_rd_addr_nxt  = ADDR_BITS'(rs);
            w_rd_valid_nxt = 1'b1;
            w_err_nxt      = 1'b0;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_REQ;
          end else if (core_state == CS_REQUEST && decoded_mem_write_enable) begin
            w_wr_addr_nxt  = ADDR_BITS'(rs);
            w_wr_data_nxt  = DATA_BITS'(rt);
            w_wr_valid_nxt = 1'b1;
            w_err_nxt      = 1'b0;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_REQ;
          end
        end
        S_REQ: begin
          if (w_ready) begin
            if (r_rd_valid) w_out_nxt = mem_read_data;
            w_rd_valid_nxt = 1'b0;
            w_wr_valid_nxt = 1'b0;
            w_state_nxt    = S_DONE;
          end else if (w_timeout) begin
            if (r_rd_valid) w_out_nxt = '0;
            w_rd_valid_nxt = 1'b0;
            w_wr_valid_nxt = 1'b0;
            w_err_nxt      = 1'b1;
            w_state_nxt    = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (core_state == CS_UPDATE) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_out      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_out      <= w_out_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign mem_read_valid    = r_rd_valid;
  assign mem_read_address  = r_rd_addr;
  assign mem_write_valid   = r_wr_valid;
  assign mem_write_address = r_wr_addr;
  assign mem_write_data    = r_wr_data;
  assign lsu_state         = r_state;
  assign lsu_out           = r_out;
  assign lsu_error         = r_err;

endmodule

// File: tb/tb_thread_lsu.sv
// Bench for thread_lsu: a transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_thread_lsu;
  localparam int T = 4;
  localparam logic [3:0] CS_REQ  = 4'b0100;
  localparam logic [3:0] CS_WAIT = 4'b0110;
  localparam logic [3:0] CS_UPD  = 4'b0111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] core_state = 4'h0;
  logic       rd_en = 1'b0, wr_en = 1'b0;
  logic [7:0] rs = 8'h00, rt = 8'h00;
  logic       mem_read_valid, mem_write_valid;
  logic [7:0] mem_read_address, mem_write_address, mem_write_data;
  logic       mem_read_ready = 1'b0, mem_write_ready = 1'b0;
  logic [7:0] mem_read_data = 8'h00;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rv_cycles = 0;
  int wv_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending transaction is described by its kind and how many
  // enabled cycles it has been outstanding.
  bit   m_live = 0;
  int   m_phase = 0;      // 0 idle, 1 outstanding, 3 finished
  int   m_kind = 0;       // 1 load, 2 store
  int   m_elapsed = 0;
  logic [7:0] m_raddr = 0, m_waddr = 0, m_wdata = 0, m_out = 0;
  bit   m_err = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_phase = 0; m_kind = 0; m_elapsed = 0;
      m_raddr = 0; m_waddr = 0; m_wdata = 0; m_out = 0; m_err = 0;
    end else if (enable) begin
      if (m_phase == 0) begin
        if (core_state == CS_REQ && (rd_en || wr_en)) begin
          m_kind = rd_en ? 1 : 2;
          if (m_kind == 1) m_raddr = rs;
          else begin m_waddr = rs; m_wdata = rt; end
          m_err = 0; m_elapsed = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_elapsed++;
        if ((m_kind == 1) ? mem_read_ready : mem_write_ready) begin
          if (m_kind == 1) m_out = mem_read_data;
          m_phase = 3;
        end else if (T != 0 && m_elapsed == T) begin
          if (m_kind == 1) m_out = 0;
          m_err = 1; m_phase = 3;
        end
      end else if (core_state == CS_UPD) begin
        m_phase = 0;
      end
    end
    #1;
    if (m_live) begin
      check("cyc_state", lsu_state, m_phase);
      check("cyc_rvalid", mem_read_valid, (m_phase == 1 && m_kind == 1));
      check("cyc_wvalid", mem_write_valid, (m_phase == 1 && m_kind == 2));
      check("cyc_raddr", mem_read_address, m_raddr);
      check("cyc_waddr", mem_write_address, m_waddr);
      check("cyc_wdata", mem_write_data, m_wdata);
      check("cyc_out", lsu_out, m_out);
      check("cyc_err", lsu_error, m_err);
    end
    rv_cycles += int'(mem_read_valid);
    wv_cycles += int'(mem_write_valid);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    core_state = CS_REQ; rd_en = rd; wr_en = wr; rs = a; rt = d;
    rv_cycles = 0; wv_cycles = 0;
    cyc(1);
    core_state = CS_WAIT;
  endtask

  task automatic update();
    core_state = CS_UPD;
    cyc(1);
    core_state = CS_WAIT; rd_en = 0; wr_en = 0;
    check("upd_idle", lsu_state, 2'b00);
  endtask

  initial begin
    cyc(2);
    check("rst_state", lsu_state, 2'b00);
    check("rst_out", lsu_out, 8'h00);
    check("rst_valids", {mem_read_valid, mem_write_valid}, 2'b00);
    reset = 0;
    cyc(1);

    // load, ready sampled on the third edge after valid rises
    issue(1, 0, 8'h1A, 8'h00);
    cyc(2);
    mem_read_ready = 1; mem_read_data = 8'h5C;
    cyc(1);
    mem_read_ready = 0; mem_read_data = 8'h00;
    check("ld_state", lsu_state, 2'b11);
    check("ld_out", lsu_out, 8'h5C);
    check("ld_addr", mem_read_address, 8'h1A);
    check("ld_vcycles", rv_cycles, 3);
    cyc(2);
    check("ld_hold", lsu_state, 2'b11);
    update();
    check("ld_out_kept", lsu_out, 8'h5C);

    // store accepted on the first edge
    issue(0, 1, 8'h02, 8'hF0);
    mem_write_ready = 1;
    cyc(1);
    mem_write_ready = 0;
    check("st_state", lsu_state, 2'b11);
    check("st_vcycles", wv_cycles, 1);
    check("st_addr", mem_write_address, 8'h02);
    check("st_data", mem_write_data, 8'hF0);
    check("st_out", lsu_out, 8'h5C);
    update();

    // read and write both decoded: read only, write-ready ignored
    issue(1, 1, 8'h33, 8'h44);
    mem_write_ready = 1;
    cyc(1);
    mem_read_ready = 1; mem_read_data = 8'h77;
    cyc(1);
    mem_read_ready = 0; mem_write_ready = 0;
    check("both_wcycles", wv_cycles, 0);
    check("both_rcycles", rv_cycles, 2);
    check("both_out", lsu_out, 8'h77);
    check("both_waddr", mem_write_address, 8'h02);
    update();

    // timeout on a load that never gets ready
    issue(1, 0, 8'h55, 8'h00);
    cyc(4);
    check("to_state", lsu_state, 2'b11);
    check("to_err", lsu_error, 1'b1);
    check("to_out", lsu_out, 8'h00);
    check("to_vcycles", rv_cycles, T);
    update();
    check("to_err_kept", lsu_error, 1'b1);
    issue(0, 1, 8'h10, 8'h20);
    check("to_err_clr", lsu_error, 1'b0);
    mem_write_ready = 1;
    cyc(1);
    mem_write_ready = 0;
    check("to_next_done", lsu_state, 2'b11);
    update();

    // disabled while requesting: ready pulse ignored, counter frozen
    issue(1, 0, 8'h66, 8'h00);
    cyc(1);
    enable = 0;
    cyc(1);
    mem_read_ready = 1; mem_read_data = 8'h11;
    cyc(1);
    mem_read_ready = 0; mem_read_data = 8'h00;
    cyc(3);
    check("en_frozen", lsu_state, 2'b01);
    enable = 1;
    cyc(1);
    mem_read_ready = 1; mem_read_data = 8'h9A;
    cyc(1);
    mem_read_ready = 0;
    check("en_state", lsu_state, 2'b11);
    check("en_out", lsu_out, 8'h9A);
    check("en_err", lsu_error, 1'b0);
    check("en_vcycles", rv_cycles, 8);
    update();

    // reset in the middle of a load
    issue(1, 0, 8'h77, 8'h00);
    reset = 1;
    cyc(1);
    reset = 0;
    check("rr_valid", mem_read_valid, 1'b0);
    check("rr_state", lsu_state, 2'b00);
    check("rr_out", lsu_out, 8'h00);
    cyc(3);
    check("rr_no_done", lsu_state, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/thread_lsu.md
Name: thread_lsu

Overview:
- Per-thread load/store unit: the consumer of the register file's rs/rt read outputs and the producer of its lsu_out write-back input.
- On LDR/STR it issues one valid/ready transaction to the memory controller and returns load data.
- It reports completion through lsu_state so the scheduler can leave WAIT.
- One instance per thread, alongside the ALU and register file; gated by the same per-thread enable.

Parameters:
ADDR_BITS, 8, memory address width; address = rs[ADDR_BITS-1:0], zero-extended when ADDR_BITS > 8
DATA_BITS, 8, memory data width
TIMEOUT_CYCLES, 64, max cycles REQUESTING may wait for ready before aborting; 0 disables timeout

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  thread active in current block; when low the unit holds all state
core_state  input  4  scheduler state: 4'b0100 REQUEST, 4'b0111 UPDATE
decoded_mem_read_enable  input  1  current instruction is LDR
decoded_mem_write_enable  input  1  current instruction is STR
rs  input  8  address operand from register file
rt  input  8  store data operand from register file
mem_read_valid  output  1  read request valid
mem_read_address  output  ADDR_BITS  read address
mem_read_ready  input  1  controller accepts read; data valid this cycle
mem_read_data  input  DATA_BITS  read data
mem_write_valid  output  1  write request valid
mem_write_address  output  ADDR_BITS  write address
mem_write_data  output  DATA_BITS  write data = rt[DATA_BITS-1:0]
mem_write_ready  input  1  controller accepts write
lsu_state  output  2  00 IDLE, 01 REQUESTING, 11 DONE (10 unused)
lsu_out  output  DATA_BITS  last load result
lsu_error  output  1  sticky-per-instruction timeout flag

Behaviour:
- Reset values: lsu_state=IDLE, both valids=0, both addresses=0, mem_write_data=0, lsu_out=0, lsu_error=0, timeout counter=0. Reset mid-transaction drops valid next edge; no completion is reported.
- All outputs registered. enable=0: no state change, outputs hold; valids stay as they are.
- IDLE:
  - If core_state==REQUEST and read_enable: latch address from rs, mem_read_valid<=1, clear lsu_error, -> REQUESTING.
  - Else if core_state==REQUEST and write_enable: latch address from rs and data from rt, mem_write_valid<=1, clear lsu_error, -> REQUESTING.
  - Read and write both high: read wins; no write is issued.
  - Neither high: stay IDLE.
- REQUESTING:
  - Address/data stable while valid is high.
  - Read, mem_read_ready==1 at posedge: lsu_out<=mem_read_data, mem_read_valid<=0, -> DONE.
  - Write, mem_write_ready==1: mem_write_valid<=0, -> DONE.
  - Transfer latency is 1 cycle minimum, from the edge valid rises to the first edge ready is sampled high.
  - Ready sampled only on the active channel; ready on the idle channel is ignored.
- Timeout:
  - Counter resets on entry to REQUESTING and increments each enabled cycle without ready.
  - When the counter == TIMEOUT_CYCLES-1 and ready is still low (TIMEOUT_CYCLES != 0): drop valid, lsu_error<=1, -> DONE. On a read abort, lsu_out<=0.
  - Ready arriving in the abort cycle wins: normal completion, no error.
- DONE: hold until core_state==UPDATE, then -> IDLE on that edge. lsu_out and lsu_error hold through UPDATE so the register file samples them. A new REQUEST is not accepted in DONE.
- Scheduler contract: the scheduler waits while any active thread lsu_state != DONE for LDR/STR.

Test Plan:
- rs=8'h1A, LDR, REQUEST; ready high 3 cycles later with data 8'h5C -> mem_read_valid high 3 cycles, address 8'h1A; lsu_out=8'h5C; lsu_state DONE until UPDATE, then IDLE.
- rs=8'h02, rt=8'hF0, STR; ready same cycle valid first seen -> one-cycle valid, write_address 8'h02, write_data 8'hF0, lsu_out unchanged.
- Read and write enable both high -> only read channel asserted; mem_write_valid stays 0 throughout.
- TIMEOUT_CYCLES=4, LDR, ready never asserted -> valid high exactly 4 cycles then 0, lsu_error=1, lsu_out=0, DONE; next instruction clears lsu_error.
- enable=0 for 5 cycles while REQUESTING, with ready pulsed during that time -> no completion, counter frozen; after enable=1 and ready -> normal completion.
- Reset asserted while REQUESTING -> next cycle valid=0, lsu_state=IDLE, lsu_out=0; no spurious DONE.
